// File: rtl/title_screen_ctrl.sv
// Screen sequencer (TITLE / PLAY / OVER) with PRESS START blink, game-over hold timer
// and per-pixel logo overlay selection for the colour mapper.
module title_screen_ctrl #(
    parameter int unsigned HOLD_FRAMES = 180,
    parameter int unsigned BLINK_BITS  = 6,
    parameter logic [23:0] LOGO_RGB    = 24'hFFD000,
    parameter logic [23:0] OVER_RGB    = 24'hFF0000,
    parameter logic [23:0] START_RGB   = 24'hFFFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        start_key,
    input  logic        player_dead,
    input  logic        is_galaga,
    input  logic        is_gameover,
    input  logic        is_press_start,
    output logic [1:0]  screen,
    output logic        game_start,
    output logic        overlay_on,
    output logic [23:0] overlay_rgb
);

    typedef enum logic [1:0] {
        ST_TITLE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    localparam logic [9:0] HOLD_LAST = 10'(HOLD_FRAMES - 1);

    state_t                r_state;
    state_t                w_state_d;
    logic                  w_game_start_d;
    logic                  r_game_start;
    logic                  r_fsync1;
    logic                  r_fsync2;
    logic                  r_fprev;
    logic                  r_key;
    logic                  r_key_q;
    logic                  r_key_armed;
    logic [BLINK_BITS-1:0] r_blink_cnt;
    logic [9:0]            r_hold_cnt;
    logic                  w_frame_tick;
    logic                  w_start_edge;
    logic                  w_blink_vis;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_fsync1 <= 1'b0;
            r_fsync2 <= 1'b0;
            r_fprev  <= 1'b0;
        end else begin
            r_fsync1 <= frame_clk;
            r_fsync2 <= r_fsync1;
            r_fprev  <= r_fsync2;
        end
    end

    assign w_frame_tick = r_fsync2 & ~r_fprev;

    // Arming requires the key to be seen low after reset, so a key held through
    // reset release never produces an edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_key       <= 1'b0;
            r_key_q     <= 1'b0;
            r_key_armed <= 1'b0;
        end else begin
            r_key       <= start_key;
            r_key_q     <= r_key;
            r_key_armed <= r_key_armed | ~start_key;
        end
    end

    assign w_start_edge = r_key & ~r_key_q & r_key_armed;

    always_comb begin
        w_state_d      = r_state;
        w_game_start_d = 1'b0;
        case (r_state)
            ST_TITLE: begin
                if (w_start_edge) begin
                    w_state_d      = ST_PLAY;
                    w_game_start_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (player_dead) begin
                    w_state_d = ST_OVER;
                end
            end
            ST_OVER: begin
                if (w_frame_tick && (r_hold_cnt == HOLD_LAST)) begin
                    w_state_d = ST_TITLE;
                end
            end
            default: w_state_d = ST_TITLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= ST_TITLE;
            r_game_start <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_game_start <= w_game_start_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_blink_cnt <= '0;
            r_hold_cnt  <= '0;
        end else begin
            if ((r_state != ST_TITLE) && (w_state_d == ST_TITLE)) begin
                r_blink_cnt <= '0;
            end else if ((r_state == ST_TITLE) && w_frame_tick) begin
                r_blink_cnt <= r_blink_cnt + BLINK_BITS'(1);
            end
            if ((r_state != ST_OVER) && (w_state_d == ST_OVER)) begin
                r_hold_cnt <= '0;
            end else if ((r_state == ST_OVER) && w_frame_tick) begin
                r_hold_cnt <= r_hold_cnt + 10'd1;
            end
        end
    end

    assign w_blink_vis = ~r_blink_cnt[BLINK_BITS-1];

    always_comb begin
        overlay_on  = 1'b0;
        overlay_rgb = 24'h0;
        case (r_state)
            ST_TITLE: begin
                if (is_galaga) begin
                    overlay_on  = 1'b1;
                    overlay_rgb = LOGO_RGB;
                end else if (is_press_start && w_blink_vis) begin
                    overlay_on  = 1'b1;
                    overlay_rgb = START_RGB;
                end
            end
            ST_OVER: begin
                if (is_gameover) begin
                    overlay_on  = 1'b1;
                    overlay_rgb = OVER_RGB;
                end
            end
            default: begin
                overlay_on  = 1'b0;
                overlay_rgb = 24'h0;
            end
        endcase
    end

    assign screen     = r_state;
    assign game_start = r_game_start;

endmodule

// File: tb/tb_title_screen_ctrl.sv
// Directed-plus-random bench for title_screen_ctrl against a frame/press-level model.
module tb_title_screen_ctrl;

    localparam int unsigned HOLD = 4;
    localparam int unsigned BB   = 6;

    logic        Clk;
    logic        Reset;
    logic        frame_clk;
    logic        start_key;
    logic        player_dead;
    logic        is_galaga;
    logic        is_gameover;
    logic        is_press_start;
    logic [1:0]  screen;
    logic        game_start;
    logic        overlay_on;
    logic [23:0] overlay_rgb;

    int n_vec;
    int n_err;

    // Model: screen, ticks counted since entering TITLE, ticks in OVER, key armed.
    int m_screen;
    int m_blink;
    int m_hold;
    bit m_armed;

    title_screen_ctrl #(
        .HOLD_FRAMES (HOLD),
        .BLINK_BITS  (BB),
        .LOGO_RGB    (24'hFFD000),
        .OVER_RGB    (24'hFF0000),
        .START_RGB   (24'hFFFFFF)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_clk      (frame_clk),
        .start_key      (start_key),
        .player_dead    (player_dead),
        .is_galaga      (is_galaga),
        .is_gameover    (is_gameover),
        .is_press_start (is_press_start),
        .screen         (screen),
        .game_start     (game_start),
        .overlay_on     (overlay_on),
        .overlay_rgb    (overlay_rgb)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_screen"}, 32'(screen), 32'(m_screen));
        chk({tag, "_gs"}, 32'(game_start), 32'd0);
    endtask

    task automatic check_ov_with(input string tag, input bit g, input bit o, input bit p);
        bit          e_on;
        logic [23:0] e_rgb;
        bit          vis;
        is_galaga      = g;
        is_gameover    = o;
        is_press_start = p;
        #1;
        vis   = (m_blink % (1 << BB)) < (1 << (BB - 1));
        e_on  = 1'b0;
        e_rgb = 24'h0;
        if (m_screen == 0) begin
            if (g) begin
                e_on  = 1'b1;
                e_rgb = 24'hFFD000;
            end else if (p && vis) begin
                e_on  = 1'b1;
                e_rgb = 24'hFFFFFF;
            end
        end else if (m_screen == 2 && o) begin
            e_on  = 1'b1;
            e_rgb = 24'hFF0000;
        end
        chk({tag, "_on"}, 32'(overlay_on), 32'(e_on));
        chk({tag, "_rgb"}, 32'(overlay_rgb), 32'(e_rgb));
    endtask

    task automatic check_ov(input string tag);
        check_ov_with(tag, 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic frame();
        frame_clk = 1'b1;
        repeat ($urandom_range(3, 6)) @(negedge Clk);
        if (m_screen == 0) begin
            m_blink++;
        end else if (m_screen == 2) begin
            if (m_hold == HOLD - 1) begin
                m_screen = 0;
                m_blink  = 0;
            end else begin
                m_hold++;
            end
        end
        frame_clk = 1'b0;
        repeat ($urandom_range(3, 6)) @(negedge Clk);
    endtask

    task automatic press();
        bit go;
        go = (m_screen == 0) && m_armed;
        start_key = 1'b1;
        @(negedge Clk);
        #1;
        chk("press_c1_screen", 32'(screen), 32'(m_screen));
        chk("press_c1_gs", 32'(game_start), 32'd0);
        @(negedge Clk);
        #1;
        if (go) m_screen = 1;
        chk("press_c2_screen", 32'(screen), 32'(m_screen));
        chk("press_c2_gs", 32'(game_start), 32'(go));
        repeat ($urandom_range(2, 8)) begin
            @(negedge Clk);
            #1;
            chk("press_hold_screen", 32'(screen), 32'(m_screen));
            chk("press_hold_gs", 32'(game_start), 32'd0);
        end
        start_key = 1'b0;
        m_armed   = 1'b1;
        @(negedge Clk);
    endtask

    task automatic dead(input bit keep);
        player_dead = 1'b1;
        @(negedge Clk);
        #1;
        if (m_screen == 1) begin
            m_screen = 2;
            m_hold   = 0;
        end
        check_state("dead");
        if (!keep) player_dead = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        Reset = 1'b0;
        frame_clk = 1'b0;
        start_key = 1'b0;
        player_dead = 1'b0;
        is_galaga = 1'b0;
        is_gameover = 1'b0;
        is_press_start = 1'b0;
        m_screen = 0;
        m_blink  = 0;
        m_hold   = 0;
        m_armed  = 1'b0;

        repeat (3) @(negedge Clk);
        check_state("rst");
        check_ov_with("rst_ov", 1'b0, 1'b0, 1'b1);
        Reset   = 1'b1;
        m_armed = 1'b1;
        repeat (2) @(negedge Clk);

        // Three frames with no key: stay in TITLE, PRESS START still visible.
        repeat (3) begin
            frame();
            check_state("title_frames");
        end
        check_ov_with("blink3_start", 1'b0, 1'b0, 1'b1);
        check_ov_with("blink3_galaga", 1'b1, 1'b0, 1'b1);

        press();
        check_state("after_press");
        check_ov_with("play_all", 1'b1, 1'b1, 1'b1);
        press();
        check_state("play_press_ignored");

        dead(1'b0);
        check_ov_with("over_go", 1'b0, 1'b1, 1'b0);
        check_ov_with("over_galaga", 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < int'(HOLD); i++) begin
            if (i == 1) press();
            frame();
            check_state("over_hold");
        end

        // Full blink period: visible for 32 ticks, hidden for the next 32.
        for (int f = 0; f < 64; f++) begin
            check_ov_with("blink_sweep", 1'b0, 1'b0, 1'b1);
            if (f % 8 == 0) check_ov_with("blink_galaga", 1'b1, 1'b0, 1'b1);
            frame();
        end
        check_ov_with("blink_wrap", 1'b0, 1'b0, 1'b1);

        // Dead held through OVER and back into TITLE.
        press();
        dead(1'b1);
        repeat (HOLD) frame();
        check_state("dead_held_title");
        repeat (4) @(negedge Clk);
        check_state("dead_held_title2");
        player_dead = 1'b0;

        // Reset mid-OVER with the key held through release.
        press();
        dead(1'b0);
        repeat (2) frame();
        start_key = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        m_screen = 0;
        m_blink  = 0;
        m_hold   = 0;
        m_armed  = 1'b0;
        check_state("mid_reset");
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        repeat (6) begin
            @(negedge Clk);
            #1;
            check_state("held_key");
        end
        start_key = 1'b0;
        m_armed   = 1'b1;
        repeat (2) @(negedge Clk);
        press();
        check_state("repress");
        dead(1'b0);
        repeat (HOLD) frame();
        check_state("hold_cleared");

        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 3))
                0: frame();
                1: press();
                2: dead(1'b0);
                default: check_ov("rand_ov");
            endcase
            check_state("rand");
            check_ov("rand_ov2");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
